// File: rtl/espi_pkg.sv
// Shared definitions for the eSPI master PHY: FSM state encoding, CRC-8
// polynomial, command read-bit index and turnaround length.
// When ESPI_CRC_EN is defined the CRC state is added to the state set.
package espi_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CS_SETUP = 4'd1,
    CMD      = 4'd2,
    WR_DATA  = 4'd3,
    TAR      = 4'd4,
    RD_DATA  = 4'd5,
    CS_HOLD  = 4'd6,
    DONE     = 4'd7
`ifdef ESPI_CRC_EN
    , CRC    = 4'd8
`endif
  } espi_state_e;

  localparam logic [7:0] CRC8_POLY    = 8'h07;
  localparam int         CMD_READ_BIT = 7;
  localparam int         TAR_BITS     = 2;

endpackage

// File: rtl/espi_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00, MSB first), one bit per enabled clk.
// Only present in builds with ESPI_CRC_EN defined.
`ifdef ESPI_CRC_EN
module espi_crc8
  import espi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [7:0] crc
);

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic d);
    logic fb;
    fb = c[7] ^ d;
    return {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

  // Running remainder: cleared at transaction acceptance, advanced per serial bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       crc <= 8'h00;
    else if (clear)  crc <= 8'h00;
    else if (enable) crc <= crc8_step(crc, din);
  end

endmodule
`endif

// File: rtl/espi_master_phy.sv
// eSPI-style single-wire master PHY: chip select, mode-0 serial clock,
// command byte, write byte or turnaround + read byte, then chip-select hold.
// Optional CRC-8 phase compiled in with the ESPI_CRC_EN macro.
module espi_master_phy
  import espi_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_transaction,
  input  logic [7:0] command,
  input  logic [7:0] write_data,
  output logic [7:0] read_data,
  output logic       transaction_done,
  output logic       busy,
  output logic       crc_err,
  output logic       sclk,
  output logic       cs_n,
  inout  wire        io0
);

  localparam logic [7:0] HALF_LOAD = 8'(SCLK_HALF - 1);
  localparam logic [3:0] TAR_LOAD  = 4'(TAR_BITS - 1);

  espi_state_e state;
  logic [7:0]  half_cnt;
  logic [3:0]  bit_cnt;
  logic        io_oe;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  cmd_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rx_result;

  logic half_done;
  logic bit_phase;
  logic rx_phase;
  logic sclk_rise;
  logic is_read;
  logic release_tar;

  // Master drives only the MSB of the transmit shifter, and only when enabled
  assign io0 = io_oe ? tx_sh[7] : 1'bz;

  assign is_read   = cmd_q[CMD_READ_BIT];
  assign half_done = (half_cnt == 8'd0);

  // Phase decode: which states run the bit engine and which of them receive
  always_comb begin
    bit_phase = (state == CMD) || (state == WR_DATA) || (state == TAR) || (state == RD_DATA);
    rx_phase  = (state == RD_DATA);
`ifdef ESPI_CRC_EN
    bit_phase = bit_phase || (state == CRC);
    rx_phase  = rx_phase || ((state == CRC) && is_read);
`endif
  end

  assign sclk_rise = bit_phase && half_done && !sclk;

  // Drop the drive exactly one clk before the last command bit ends on reads
  assign release_tar = (state == CMD) && is_read && (bit_cnt == 4'd0) &&
                       ((SCLK_HALF == 1) ? sclk_rise : (sclk && (half_cnt == 8'd1)));

`ifdef ESPI_CRC_EN
  logic [7:0] crc_val;
  logic [7:0] rx_byte;
  logic       crc_en;
  logic       crc_din;
  logic       crc_clr;

  assign crc_clr = (state == IDLE) && start_transaction;
  assign crc_en  = sclk_rise && ((state == CMD) || (state == WR_DATA) || (state == RD_DATA));
  assign crc_din = (state == RD_DATA) ? io0 : tx_sh[7];

  espi_crc8 u_crc8 (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clr),
    .enable (crc_en),
    .din    (crc_din),
    .crc    (crc_val)
  );

  assign rx_result = rx_byte;

  // CRC verdict for reads, cleared for writes, updated at transaction end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               crc_err <= 1'b0;
    else if (state == DONE)  crc_err <= is_read ? (rx_sh != crc_val) : 1'b0;
  end
`else
  assign rx_result = rx_sh;
  assign crc_err   = 1'b0;
`endif

  // Transaction sequencer: chip select, serial clock, bit shifting and handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      half_cnt         <= 8'h00;
      bit_cnt          <= 4'd0;
      sclk             <= 1'b0;
      cs_n             <= 1'b1;
      io_oe            <= 1'b0;
      tx_sh            <= 8'h00;
      rx_sh            <= 8'h00;
      cmd_q            <= 8'h00;
      wdata_q          <= 8'h00;
      busy             <= 1'b0;
      transaction_done <= 1'b0;
      read_data        <= 8'h00;
`ifdef ESPI_CRC_EN
      rx_byte          <= 8'h00;
`endif
    end else begin
      transaction_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_transaction) begin
            state    <= CS_SETUP;
            cmd_q    <= command;
            wdata_q  <= write_data;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            half_cnt <= HALF_LOAD;
          end else begin
            busy <= 1'b0;
          end
        end
        CS_SETUP: begin
          if (half_done) begin
            state    <= CMD;
            half_cnt <= HALF_LOAD;
            bit_cnt  <= 4'd7;
            tx_sh    <= cmd_q;
            io_oe    <= 1'b1;
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end
        CS_HOLD: begin
          if (half_done) begin
            state <= DONE;
            cs_n  <= 1'b1;
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end
        DONE: begin
          state            <= IDLE;
          transaction_done <= 1'b1;
          if (is_read) read_data <= rx_result;
        end
        default: begin
          if (!bit_phase) begin
            state <= IDLE;
          end else if (!half_done) begin
            half_cnt <= half_cnt - 8'd1;
          end else begin
            half_cnt <= HALF_LOAD;
            sclk     <= ~sclk;
            if (!sclk) begin
              // Rising sclk edge: sample the line
              if (rx_phase) rx_sh <= {rx_sh[6:0], io0};
            end else if (bit_cnt != 4'd0) begin
              // Falling sclk edge inside a phase: present the next bit
              bit_cnt <= bit_cnt - 4'd1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
            end else begin
              // Falling sclk edge after the last bit: next phase
              case (state)
                CMD: begin
                  if (is_read) begin
                    state   <= TAR;
                    bit_cnt <= TAR_LOAD;
                  end else begin
                    state   <= WR_DATA;
                    bit_cnt <= 4'd7;
                    tx_sh   <= wdata_q;
                  end
                end
                TAR: begin
                  state   <= RD_DATA;
                  bit_cnt <= 4'd7;
                end
                WR_DATA: begin
`ifdef ESPI_CRC_EN
                  state   <= CRC;
                  bit_cnt <= 4'd7;
                  tx_sh   <= crc_val;
`else
                  state   <= CS_HOLD;
                  io_oe   <= 1'b0;
`endif
                end
                RD_DATA: begin
`ifdef ESPI_CRC_EN
                  state   <= CRC;
                  bit_cnt <= 4'd7;
                  rx_byte <= rx_sh;
`else
                  state   <= CS_HOLD;
`endif
                end
                default: begin
                  state <= CS_HOLD;
                  io_oe <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
      if (release_tar) io_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_espi_master_phy.sv
// Self-checking bench for espi_master_phy with a behavioural slave and a
// transaction-level reference model (bit stream, timing, read data, CRC).
module tb_espi_master_phy;

  localparam int H = 2;
`ifdef ESPI_CRC_EN
  localparam bit CRC_ON   = 1'b1;
  localparam int SLV_BITS = 16;
`else
  localparam bit CRC_ON   = 1'b0;
  localparam int SLV_BITS = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_transaction = 1'b0;
  logic [7:0] command = 8'h00;
  logic [7:0] write_data = 8'h00;
  logic [7:0] read_data;
  logic       transaction_done;
  logic       busy;
  logic       crc_err;
  logic       sclk;
  logic       cs_n;
  wire        io0;

  logic       slv_en = 1'b0;
  logic       slv_bit = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_rd = 8'h00;

  pullup (io0);
  assign io0 = (slv_en && !cs_n) ? slv_bit : 1'bz;

  espi_master_phy #(.SCLK_HALF(H)) dut (
    .clk               (clk),
    .reset             (reset),
    .start_transaction (start_transaction),
    .command           (command),
    .write_data        (write_data),
    .read_data         (read_data),
    .transaction_done  (transaction_done),
    .busy              (busy),
    .crc_err           (crc_err),
    .sclk              (sclk),
    .cs_n              (cs_n),
    .io0               (io0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, want);
  endtask

  // Byte-wise CRC-8 over the two bytes carried on the wire
  function automatic logic [7:0] crc8_pair(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] bytes [2];
    c = 8'h00;
    bytes[0] = a;
    bytes[1] = b;
    for (int n = 0; n < 2; n++) begin
      c = c ^ bytes[n];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // One transaction: poke_cyc>0 pulses start mid-transfer, rst_rise>0 resets after that sclk rise
  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] wd, input logic [7:0] sdata,
                         input logic flip_crc, input int poke_cyc, input int rst_rise);
    logic        rd;
    logic        rose;
    logic        prev_sclk;
    logic [7:0]  good_crc;
    logic [7:0]  scrc;
    logic [31:0] exp_vec;
    logic [31:0] got_vec;
    int          exp_n, exp_low, rises, cyc, low_cnt, k, extra_done, extra_low;

    rd       = cmd[7];
    good_crc = crc8_pair(cmd, rd ? sdata : wd);
    scrc     = good_crc ^ {7'd0, flip_crc};

    // Expected io0 value at each sclk rising edge
    exp_vec = 32'd0;
    exp_n   = 0;
    for (int i = 7; i >= 0; i--) begin exp_vec = {exp_vec[30:0], cmd[i]}; exp_n++; end
    if (rd) begin
      for (int i = 0; i < 2; i++) begin exp_vec = {exp_vec[30:0], 1'b1}; exp_n++; end
      for (int i = 7; i >= 0; i--) begin exp_vec = {exp_vec[30:0], sdata[i]}; exp_n++; end
      if (CRC_ON) for (int i = 7; i >= 0; i--) begin exp_vec = {exp_vec[30:0], scrc[i]}; exp_n++; end
    end else begin
      for (int i = 7; i >= 0; i--) begin exp_vec = {exp_vec[30:0], wd[i]}; exp_n++; end
      if (CRC_ON) for (int i = 7; i >= 0; i--) begin exp_vec = {exp_vec[30:0], good_crc[i]}; exp_n++; end
    end
    exp_low = H * (2 + 32 + (rd ? 4 : 0) + (CRC_ON ? 16 : 0));

    slv_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    command = cmd;
    write_data = wd;
    start_transaction = 1'b1;
    @(posedge clk); #1;
    start_transaction = 1'b0;
    command = 8'($urandom);
    write_data = 8'($urandom);
    chk("busy_accept", 32'(busy), 32'd1);
    chk("cs_fall", 32'(cs_n), 32'd0);

    cyc = 0; rises = 0; low_cnt = 1; got_vec = 32'd0; prev_sclk = sclk;
    while (!transaction_done && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      start_transaction = (cyc == poke_cyc);
      if (!cs_n) low_cnt++;
      rose = sclk && !prev_sclk;
      if (rose) begin
        rises++;
        got_vec = {got_vec[30:0], io0};
      end
      if (!sclk && prev_sclk && rd && rises >= 10) begin
        k = rises - 10;
        slv_en = (k < SLV_BITS);
        if (k < 8) slv_bit = sdata[7-k];
        else if (k < 16) slv_bit = scrc[15-k];
      end
      prev_sclk = sclk;
      if (rst_rise != 0 && rose && rises == rst_rise) begin
        reset = 1'b1;
        #1;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_io0_released", 32'(io0), 32'd1);
        chk("rst_done", 32'(transaction_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read_data", 32'(read_data), 32'd0);
        exp_rd = 8'h00;
        start_transaction = 1'b0;
        return;
      end
    end
    start_transaction = 1'b0;

    chk("done_latency", 32'(cyc), 32'(exp_low + 1));
    chk("cs_low_clks", 32'(low_cnt), 32'(exp_low));
    chk("bit_count", 32'(rises), 32'(exp_n));
    chk("bit_stream", got_vec, exp_vec);
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("cs_high_at_done", 32'(cs_n), 32'd1);
    if (rd) exp_rd = sdata;
    chk("read_data", 32'(read_data), 32'(exp_rd));
    chk("crc_err", 32'(crc_err), 32'(CRC_ON && rd && flip_crc));

    extra_done = 0; extra_low = 0;
    repeat (4) begin
      @(posedge clk); #1;
      extra_done += 32'(transaction_done);
      extra_low  += 32'(!cs_n);
    end
    chk("single_pulse", 32'(extra_done), 32'd0);
    chk("stays_idle", 32'(extra_low), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dcount, lat;
    logic [7:0] c, w, s;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs_n", 32'(cs_n), 32'd1);
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_done", 32'(transaction_done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_read_data", 32'(read_data), 32'd0);
    chk("reset_crc_err", 32'(crc_err), 32'd0);
    chk("reset_io0", 32'(io0), 32'd1);

    // Directed write and read, first started on the edge right after reset release
    run_txn(8'h21, 8'hA5, 8'h00, 1'b0, 0, 0);
    run_txn(8'h81, 8'hFF, 8'h3C, 1'b0, 0, 0);

    // start while busy is ignored
    run_txn(8'h21, 8'hA5, 8'h00, 1'b0, 20, 0);

    // Reset during read data bit 3 (fifth data rise), then a clean read
    run_txn(8'h81, 8'h00, 8'h3C, 1'b0, 0, 15);
    dcount = 0;
    repeat (5) begin @(posedge clk); #1; dcount += 32'(transaction_done); end
    chk("abort_no_done", 32'(dcount), 32'd0);
    chk("abort_read_data", 32'(read_data), 32'd0);
    run_txn(8'h81, 8'h00, 8'h96, 1'b0, 0, 0);

    // Corrupted CRC (flag only raised in CRC builds)
    run_txn(8'h81, 8'h00, 8'h3C, 1'b1, 0, 0);
    run_txn(8'h81, 8'h00, 8'h3C, 1'b0, 0, 0);

    // Back-to-back with start held high
    @(negedge clk);
    command = 8'h21; write_data = 8'h5A; start_transaction = 1'b1;
    cyc = 0;
    while (!transaction_done && cyc < 4000) begin @(posedge clk); #1; cyc++; end
    chk("b2b_first_done", 32'(cyc), 32'(H * (34 + (CRC_ON ? 16 : 0)) + 2));
    chk("b2b_cs_high_idle", 32'(cs_n), 32'd1);
    @(posedge clk); #1;
    chk("b2b_cs_refall", 32'(cs_n), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    start_transaction = 1'b0;
    lat = 1;
    while (!transaction_done && lat < 4000) begin @(posedge clk); #1; lat++; end
    chk("b2b_done_spacing", 32'(lat), 32'(H * (34 + (CRC_ON ? 16 : 0)) + 2));
    dcount = 0;
    repeat (5) begin @(posedge clk); #1; dcount += 32'(transaction_done) + 32'(!cs_n); end
    chk("b2b_no_third", 32'(dcount), 32'd0);

    // Randomised transactions
    for (int t = 0; t < 8; t++) begin
      c = 8'($urandom);
      w = 8'($urandom);
      s = 8'($urandom);
      run_txn(c, w, s, 1'($urandom_range(0, 1)), (t % 3 == 0) ? int'($urandom_range(5, 40)) : 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/espi_master_phy.md
ESPI_MASTER_PHY -- requirements
Module: espi_master_phy

Interface
REQ-001 SCLK_HALF, default 2, clk cycles per sclk half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_transaction  input  1  transaction request; sampled only in IDLE.
REQ-005 command  input  8  opcode; bit 7 = 1 read, 0 write; captured on acceptance.
REQ-006 write_data  input  8  write payload; captured on acceptance.
REQ-007 read_data  output  8  last byte received; updated only on read completion.
REQ-008 transaction_done  output  1  one-clk pulse at transaction end.
REQ-009 busy  output  1  high from acceptance through the transaction_done cycle.
REQ-010 crc_err  output  1  CRC mismatch flag for the last read.
REQ-011 sclk  output  1  serial clock, mode 0 (idle low).
REQ-012 cs_n  output  1  active-low chip select.
REQ-013 io0  inout  1  bidirectional data; high-Z when not driving.

Function
REQ-014 The FSM SHALL use states IDLE, CS_SETUP, CMD, WR_DATA, TAR, RD_DATA, CRC, CS_HOLD, DONE.
REQ-015 IDLE SHALL accept when start_transaction=1, capture command/write_data, and enter CS_SETUP; cs_n falls on the next clk.
REQ-016 start_transaction while busy SHALL be ignored; no queuing.
REQ-017 CS_SETUP SHALL last SCLK_HALF clk with sclk low.
REQ-018 Each bit SHALL last 2*SCLK_HALF clk: sclk low for the first half, high for the second.
REQ-019 The master SHALL change io0 only while sclk is low and sample only on the sclk rising edge.
REQ-020 CMD SHALL shift 8 command bits MSB first; then go to WR_DATA if bit 7=0, otherwise TAR.
REQ-021 WR_DATA SHALL shift write_data MSB first.
REQ-022 TAR SHALL last 2 bit times with io0 released.
REQ-023 RD_DATA SHALL sample 8 bits MSB first into a shift register.
REQ-024 CS_HOLD SHALL keep cs_n low and sclk low for SCLK_HALF clk after the last bit, then raise cs_n.
REQ-025 DONE SHALL pulse transaction_done for exactly one clk on the cycle after cs_n rises, load read_data on reads, and return to IDLE.
REQ-026 Without CRC, cs_n low time SHALL be 2*SCLK_HALF + 32*SCLK_HALF clk for a write and 2*SCLK_HALF + 36*SCLK_HALF clk for a read.
REQ-027 The bit counter SHALL be 4 bits and SHALL reload to 7 at each phase start; no wrap-around into the next phase.
REQ-028 The tri-state drive SHALL be released one clk before TAR starts; there SHALL be no overlap.

Reset
REQ-029 Reset SHALL asynchronously force IDLE with: cs_n=1, sclk=0, io0 high-Z, transaction_done=0, busy=0, read_data=8'h00, crc_err=0.
REQ-030 Reset mid-transaction SHALL abort immediately with no transaction_done pulse.
REQ-031 After reset deasserts, start_transaction SHALL be accepted from the first clk edge.

Configuration
REQ-032 Macro ESPI_CRC_EN SHALL compile in CRC-8 (poly 0x07, init 0x00, MSB first) over every bit the master transmits and receives.
REQ-033 With ESPI_CRC_EN defined:
- a CRC phase of 8 bits SHALL follow WR_DATA (master transmits the CRC) or RD_DATA (master receives and checks it);
- crc_err SHALL update in DONE for reads and clear for writes;
- cs_n low time SHALL grow by 16*SCLK_HALF clk.
REQ-034 Without ESPI_CRC_EN, there SHALL be no CRC state or CRC logic, and crc_err SHALL be tied to 0.

Structure
REQ-035 Package espi_pkg SHALL hold:
- the state enum;
- the CRC8_POLY constant (8'h07);
- the CMD_READ_BIT index (7);
- the TAR_BITS constant (2).
REQ-036 Sub-module espi_crc8 (serial 1-bit CRC update, clear and enable inputs) SHALL be instantiated only under ESPI_CRC_EN.

Verification
REQ-037 Write test: SCLK_HALF=2, command=8'h21, write_data=8'hA5, no CRC. Expected:
- io0 at the sclk rising edges reads 0010_0001_1010_0101;
- cs_n is low for 68 clk;
- transaction_done pulses 69 clk after acceptance.
REQ-038 Read test: command=8'h81, slave model drives 8'h3C after TAR. Expected:
- io0 is high-Z for 2 bit times;
- read_data=8'h3C at the transaction_done pulse;
- cs_n is low for 76 clk.
REQ-039 Busy test: a start_transaction pulse mid-write SHALL be ignored, giving exactly one transaction_done pulse and an unchanged io0 bit stream.
REQ-040 Reset test: assert reset during RD_DATA bit 3. Expected:
- cs_n=1, sclk=0, io0=Z in the same cycle;
- no transaction_done pulse;
- read_data=8'h00;
- the next transaction is correct.
REQ-041 CRC test, ESPI_CRC_EN defined: read 8'h81 with data 8'h3C and the correct CRC gives crc_err=0; the same read with the CRC bit 0 flipped gives crc_err=1.
REQ-042 Back-to-back test: start_transaction held high continuously SHALL produce transactions separated by exactly one IDLE clk with cs_n high.
